tm1638_responder: RTL
=====================

# tm1638_responder

Device-side model of the TM1638 three-wire serial interface: receives STB/CLK/DIO from a TM1638 host controller, decodes data/address/display-control commands, holds the 16-byte display RAM, and returns 4 key-scan bytes on read commands. Used as a loop-back target for host-controller bring-up on the Tang Nano 20K, and as a bus-functional responder in simulation. All pins are oversampled in the `clk` domain; no logic is clocked by the serial clock.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `stb`, `sclk`, `dio_in` (≥2).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `stb`  in  1  TM1638 STB, active-low frame select.
- `sclk`  in  1  serial clock from host; idles high.
- `dio_in`  in  1  DIO pin value as seen by the responder.
- `dio_out`  out  1  DIO value driven during key read.
- `dio_oe`  out  1  DIO output enable; top level tristates the pin when low.
- `key_state`  in  32  key-scan bytes; byte n = `key_state[8n+7:8n]`.
- `disp_ram`  out  128  display RAM; address a = `disp_ram[8a+7:8a]`.
- `disp_on`  out  1  display enable from last display-control command.
- `brightness`  out  3  pulse-width setting from last display-control command.
- `frame_done`  out  1  one-cycle pulse on each synchronized STB rising edge.

## Operation
- Byte format: LSB first; host bits sampled on synchronized `sclk` rising edge; 8 rises complete a byte.
- States: IDLE, CMD, WDATA, RDATA, IGNORE.
- IDLE → CMD on synchronized `stb` falling edge; bit counter cleared.
- Any state → IDLE on synchronized `stb` rising edge; partial byte discarded; `dio_oe` deasserted; `frame_done` pulsed.
- First byte of frame decoded in CMD:
  - `01xx_xxxx` data command: bit1=1 read, bit1=0 write; bit2=1 fixed address, 0 auto-increment; bit3 ignored. Write: mode latched, → IGNORE. Read: `key_state` snapshotted into 32-bit shift register, → RDATA.
  - `10xx_xxxx` display control: `disp_on`←bit3, `brightness`←bits[2:0]; → IGNORE.
  - `11xx_aaaa` address set: address pointer←aaaa; → WDATA.
  - `00xx_xxxx`: no effect; → IGNORE.
- WDATA: each completed byte written to `disp_ram[pointer]`; pointer then increments mod 16 (0xF wraps to 0x0) unless fixed-address mode latched.
- RDATA: on each synchronized `sclk` falling edge, `dio_oe`=1 and `dio_out`=next snapshot bit (byte0 bit0 first); after 32 bits, `dio_out`=0 for remaining falls until STB rises. Host bits ignored.
- IGNORE: further bytes consumed and discarded.
- Write/read and fixed/auto mode persist across frames until the next data command; address pointer persists.

## Timing
- Reset values: `disp_ram`=0, `disp_on`=0, `brightness`=0, `dio_oe`=0, `dio_out`=1, `frame_done`=0; mode = write, auto-increment; pointer=0; state IDLE.
- Input-to-edge-detect latency: `SYNC_STAGES`+1 clk.
- `sclk` high and low phases ≥ `SYNC_STAGES`+2 clk; `stb` setup to first `sclk` fall ≥ same.
- `dio_out`/`dio_oe` update ≤ `SYNC_STAGES`+2 clk after `sclk` fall at pin.
- `disp_ram` byte, `disp_on`, `brightness` visible 1 clk after the detected 8th rising edge.
- `stb` and `sclk` edges detected in same cycle: `stb` edge wins; `sclk` edge dropped.
- `rst_n` low mid-frame: all outputs to reset values immediately; frame abandoned; next frame requires fresh `stb` fall.
- `key_state` changes after snapshot do not affect the current read.

## Configuration
- `TM1638_RESPONDER_FIXED_ADDR_EN` defined: data command bit2 selects fixed-address mode as above.
- Not defined: bit2 ignored; WDATA always auto-increments.

## Test plan
- Frame 0x40, frame 0xC0 + 16 bytes 0x00..0x0F → `disp_ram[8a+7:8a]`=a for a=0..15; `frame_done` pulsed twice.
- Frame 0xCE + 0xAA,0xBB,0xCC → addr 14=0xAA, 15=0xBB, 0=0xCC (wrap).
- With `TM1638_RESPONDER_FIXED_ADDR_EN`: frame 0x44, frame 0xC3 + 0x11,0x22 → addr 3=0x22, addr 4 unchanged; without macro → addr 3=0x11, addr 4=0x22.
- `key_state`=0x8001_4002; frame 0x42 + 32 falls → host samples bytes 0x02,0x40,0x01,0x80 LSB first; `dio_oe` low within 4 clk of STB rise.
- Frame 0x8F → `disp_on`=1, `brightness`=7; frame 0x80 → `disp_on`=0, `brightness`=0.
- Frame 0xC5 + 0x5A with STB raised after 4 bits of second byte, then `rst_n` pulsed mid-frame → addr 5 unchanged, then all outputs at reset values.

Source files
------------

// File: rtl/tm1638_responder.sv
// tm1638_responder: device-side TM1638 serial responder, oversampled in clk.
// Decodes data / display-control / address commands, holds the 16-byte display
// RAM and shifts out 4 key-scan bytes on read commands.
//
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   stb, sclk, dio_in    TM1638 pins from the host (asynchronous)
//   dio_out, dio_oe      DIO drive value and output enable during key read
//   key_state[31:0]      key-scan bytes, byte n = key_state[8n+7:8n]
//   disp_ram[127:0]      display RAM, address a = disp_ram[8a+7:8a]
//   disp_on, brightness  last display-control settings
//   frame_done           one-cycle pulse per synchronized STB rising edge
//
// Build option: TM1638_RESPONDER_FIXED_ADDR_EN enables fixed-address mode
// (data command bit2); when undefined, writes always auto-increment.

module tm1638_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stb,
    input  logic         sclk,
    input  logic         dio_in,
    output logic         dio_out,
    output logic         dio_oe,
    input  logic [31:0]  key_state,
    output logic [127:0] disp_ram,
    output logic         disp_on,
    output logic [2:0]   brightness,
    output logic         frame_done
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned RAM_W  = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_e;

    // Pin synchronizers; STB and SCLK idle high so they reset high.
    logic [SYNC_STAGES-1:0] stb_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] dio_sync_q;
    logic                   stb_prev_q;
    logic                   sclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_sync_q  <= '1;
            sclk_sync_q <= '1;
            dio_sync_q  <= '0;
            stb_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b1;
        end else begin
            stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], stb};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], dio_in};
            stb_prev_q  <= stb_sync_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic stb_cur_c, sclk_cur_c, dio_cur_c;
    logic stb_rise_c, stb_fall_c, sclk_rise_c, sclk_fall_c;

    assign stb_cur_c   = stb_sync_q[SYNC_STAGES-1];
    assign sclk_cur_c  = sclk_sync_q[SYNC_STAGES-1];
    assign dio_cur_c   = dio_sync_q[SYNC_STAGES-1];
    assign stb_rise_c  = ~stb_prev_q & stb_cur_c;
    assign stb_fall_c  = stb_prev_q & ~stb_cur_c;
    assign sclk_rise_c = ~sclk_prev_q & sclk_cur_c;
    assign sclk_fall_c = sclk_prev_q & ~sclk_cur_c;

    // Frame state, receive shifter and register file.
    state_e              state_q;
    logic [2:0]          bit_cnt_q;
    logic [BYTE_W-2:0]   shift_q;
    logic [KEY_W-1:0]    key_sr_q;
    logic [3:0]          ptr_q;
    logic [RAM_W-1:0]    ram_q;
    logic                disp_on_q;
    logic [2:0]          bright_q;
    logic                dio_out_q;
    logic                dio_oe_q;
    logic                frame_done_q;
`ifdef TM1638_RESPONDER_FIXED_ADDR_EN
    logic                fixed_q;
`endif

    // Byte completed by the current rising edge (LSB arrived first).
    logic [BYTE_W-1:0] rx_byte_c;
    assign rx_byte_c = {dio_cur_c, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            key_sr_q     <= '0;
            ptr_q        <= '0;
            ram_q        <= '0;
            disp_on_q    <= 1'b0;
            bright_q     <= '0;
            dio_out_q    <= 1'b1;
            dio_oe_q     <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef TM1638_RESPONDER_FIXED_ADDR_EN
            fixed_q      <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            // STB edges take priority over any SCLK edge in the same cycle.
            if (stb_rise_c) begin
                state_q      <= S_IDLE;
                bit_cnt_q    <= '0;
                dio_oe_q     <= 1'b0;
                dio_out_q    <= 1'b1;
                frame_done_q <= 1'b1;
            end else if (stb_fall_c) begin
                if (state_q == S_IDLE) begin
                    state_q   <= S_CMD;
                    bit_cnt_q <= '0;
                end
            end else begin
                case (state_q)
                    S_CMD, S_WDATA, S_IGNORE: begin
                        if (sclk_rise_c) begin
                            shift_q   <= {dio_cur_c, shift_q[BYTE_W-2:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (state_q == S_CMD) begin
                                    casez (rx_byte_c)
                                        8'b01??_????: begin
`ifdef TM1638_RESPONDER_FIXED_ADDR_EN
                                            fixed_q <= rx_byte_c[2];
`endif
                                            if (rx_byte_c[1]) begin
                                                key_sr_q <= key_state;
                                                state_q  <= S_RDATA;
                                            end else begin
                                                state_q  <= S_IGNORE;
                                            end
                                        end
                                        8'b10??_????: begin
                                            disp_on_q <= rx_byte_c[3];
                                            bright_q  <= rx_byte_c[2:0];
                                            state_q   <= S_IGNORE;
                                        end
                                        8'b11??_????: begin
                                            ptr_q   <= rx_byte_c[3:0];
                                            state_q <= S_WDATA;
                                        end
                                        default: state_q <= S_IGNORE;
                                    endcase
                                end else if (state_q == S_WDATA) begin
                                    ram_q[{ptr_q, 3'b000} +: BYTE_W] <= rx_byte_c;
`ifdef TM1638_RESPONDER_FIXED_ADDR_EN
                                    if (!fixed_q) begin
                                        ptr_q <= ptr_q + 4'd1;
                                    end
`else
                                    ptr_q <= ptr_q + 4'd1;
`endif
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        // Zero fill makes the output 0 once all 32 bits are out.
                        if (sclk_fall_c) begin
                            dio_oe_q  <= 1'b1;
                            dio_out_q <= key_sr_q[0];
                            key_sr_q  <= {1'b0, key_sr_q[KEY_W-1:1]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign disp_ram   = ram_q;
    assign disp_on    = disp_on_q;
    assign brightness = bright_q;
    assign dio_out    = dio_out_q;
    assign dio_oe     = dio_oe_q;
    assign frame_done = frame_done_q;

endmodule
